fft_twiddle_seq: RTL and testbench
==================================

# fft_twiddle_seq

Parametrised per-stage control and twiddle generator for the radix-2 single-path delay-feedback (SDF) FFT pipeline. One instance sits beside each butterfly stage. It tracks the sample position within the stage and drives the stage mode (fill / load delay line / butterfly) together with the matching twiddle factor W_N^k. It generalises the fixed 4-phase stage controller to any power-of-two N, any stage index, any data width, and any pipeline fill latency, and adds burst handling with drain, a frame marker and a synchronous restart.

## Interface
- N, 128, FFT size; power of two, >= 4
- STAGE, 0, stage index, 0..log2(N)-1; delay D = N >> (STAGE+1)
- W, 24, signed twiddle width
- FRAC, 8, fractional bits; 1.0 = 2^FRAC; FRAC <= W-2
- LAT, 0, valid cycles before the first sample reaches this stage
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous restart; same effect as rst; priority over in_valid
- in_valid  in  1  input sample present this cycle
- w_r  out  W  twiddle real part, signed
- w_i  out  W  twiddle imaginary part, signed
- state  out  2  0 = FILL, 1 = LOAD, 2 = BFLY; 3 is never driven
- out_valid  out  1  outputs correspond to an advancing cycle
- sof  out  1  first sample of a frame at this stage

## Operation
- Counters:
  - lat_cnt, 0..LAT, saturating
  - phase p, 0..2D-1, wraps
  - sample s, 0..N-1, wraps
  - drain_cnt, 0..LAT+D
  - run flag
- adv = in_valid | (run & drain_cnt < LAT+D).
- First in_valid sets run.
- While in_valid is low with run set, drain_cnt increments on each advancing cycle. When drain_cnt reaches LAT+D, the drain ends: run, all counters and drain_cnt clear, and the block is ready for a new burst.
- in_valid during a drain resets drain_cnt to 0. Counting continues without a gap.
- On adv, lat_cnt increments until it equals LAT. After that, p and s increment and wrap at 2D and N.
- Decode of the pre-edge counters:
  - lat_cnt < LAT → FILL
  - p < D → LOAD
  - otherwise → BFLY
- Twiddle in BFLY: k = (p-D) << STAGE, range 0..N/2-1, W_N^k = exp(-j2πk/N). FILL and LOAD output 1+j0.
- Quarter-wave table c[i] = round(cos(2πi/N) · 2^FRAC), i = 0..N/4, rounded half away from zero.
  - k < N/4: w_r = c[k], w_i = -c[N/4-k].
  - k' = k - N/4 >= 0: w_r = -c[N/4-k'], w_i = -c[k'].
- sof = 1 when decode is non-FILL and s == 0.
- Illegal parameters (N not a power of two, STAGE out of range, FRAC > W-2) stop elaboration.

## Timing
- Reset values (rst or clr): w_r = 2^FRAC, w_i = 0, state = 0, out_valid = 0, sof = 0, all counters and run = 0.
- All outputs are registered. Latency is 1 cycle: the decode for the advancing edge at cycle t appears at cycle t+1 with out_valid = 1.
- Non-advancing cycle: out_valid = 0, sof = 0, state = 0. w_r and w_i hold their previous values.
- rst mid-frame: outputs take reset values immediately (asynchronous). The first in_valid after release starts the FILL count from 0.
- clr together with in_valid: clr wins. That in_valid is not counted.
- Wrap of p and wrap of s on the same edge: both wrap, no extra cycle.

## Structure
- fft_pkg holds:
  - clog2 function
  - ST_FILL / ST_LOAD / ST_BFLY encodings
  - the helper that computes c[i] at elaboration
  - the fixed-point rule ONE = 1 << FRAC
- Sub-module fft_twiddle_rom holds the N/4+1-entry quarter-wave table, the quadrant fold, and the output register. It takes k and a bypass flag (1+j0) and is instantiated once.
- Counters, drain logic and decode live in fft_twiddle_seq.

## Test plan
- N=8, STAGE=1, LAT=2, W=24, FRAC=8; in_valid high for 10 cycles → state 0,0,1,1,2,2,1,1,2,2; in BFLY, w = (256,0) then (0,-256), i.e. w_i = 0xFFFF00.
- N=128, STAGE=0, LAT=0, continuous valid → LOAD for 64 samples, then BFLY k = 0..63. Check k=16: w_r = 181, w_i = -181. Check k=32: w_r = 0, w_i = -256. sof every 128 outputs.
- N=16, STAGE=0, LAT=3; burst of 16 valids then in_valid low → exactly 11 further out_valid cycles (LAT+D); then run = 0 and the next burst starts with FILL ×3.
- Drain interrupted: in_valid low for 4 cycles mid-drain, then high → p and s continue without a gap, and drain_cnt restarts at the next low.
- rst asserted mid-BFLY, and separately clr asserted together with in_valid → outputs go to (256, 0, state 0, out_valid 0). The next valid restarts the FILL count.
- Sweep of N ∈ {4, 32, 1024}, all STAGE values → every BFLY twiddle is within 1 LSB of a double-precision reference. state 3 is never observed.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fft_pkg : shared stage-mode encodings and elaboration helpers for SDF FFT   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package fft_pkg;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_LOAD = 2'd1,
      ST_BFLY = 2'd2
   } stage_mode_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic longint fx_one(input int frac);
      return longint'(1) << frac;
   endfunction

   // Only first-quadrant angles are requested, so the result is never negative
   // and adding one half before truncation rounds half away from zero.
   function automatic longint cos_q(input int i, input int n, input int frac);
      real x;
      real term;
      real sum;
      real scaled;
      x    = 2.0 * 3.14159265358979323846 * real'(i) / real'(n);
      term = 1.0;
      sum  = 1.0;
      for (int m = 1; m <= 14; m++) begin
         term = -term * x * x / real'((2 * m - 1) * (2 * m));
         sum  = sum + term;
      end
      scaled = sum * real'(fx_one(frac));
      return longint'($rtoi(scaled + 0.5));
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_twiddle_rom.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fft_twiddle_rom : quarter-wave cosine table, quadrant fold, output register |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module fft_twiddle_rom
   import fft_pkg::*;
#(
   parameter int N    = 128,
   parameter int W    = 24,
   parameter int FRAC = 8,
   parameter int KW   = clog2(N) - 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                i_en,
   input  logic                i_bypass,
   input  logic [KW-1:0]       i_k,
   output logic signed [W-1:0] o_w_r,
   output logic signed [W-1:0] o_w_i
);

   localparam int              Q     = N / 4;
   localparam longint          C_ONE = fx_one(FRAC);
   localparam logic [KW-1:0]   C_Q   = KW'(Q);

   wire logic signed [W-1:0] w_tab [0:Q];

   for (genvar i = 0; i <= Q; i++) begin : g_tab
      localparam longint C_V = cos_q(i, N, FRAC);
      assign w_tab[i] = W'(C_V);
   end

   logic                w_q2;
   logic [KW-1:0]       w_kp;
   logic [KW-1:0]       w_ia;
   logic [KW-1:0]       w_ib;
   logic signed [W-1:0] w_nr;
   logic signed [W-1:0] w_ni;
   logic signed [W-1:0] r_w_r;
   logic signed [W-1:0] r_w_i;

   // Second quadrant reuses the table rotated by -j: k' = k - N/4.
   always_comb begin
      w_q2 = (i_k >= C_Q);
      w_kp = w_q2 ? (i_k - C_Q) : i_k;
      w_ia = w_kp;
      w_ib = C_Q - w_kp;
      w_nr = W'(C_ONE);
      w_ni = '0;
      if (!i_bypass) begin
         if (!w_q2) begin
            w_nr = w_tab[w_ia];
            w_ni = -w_tab[w_ib];
         end else begin
            w_nr = -w_tab[w_ib];
            w_ni = -w_tab[w_ia];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w_r <= W'(C_ONE);
         r_w_i <= '0;
      end else if (clr) begin
         r_w_r <= W'(C_ONE);
         r_w_i <= '0;
      end else if (i_en) begin
         r_w_r <= w_nr;
         r_w_i <= w_ni;
      end
   end

   assign o_w_r = r_w_r;
   assign o_w_i = r_w_i;

endmodule
`default_nettype wire

// File: rtl/fft_twiddle_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fft_twiddle_seq : per-stage mode/twiddle sequencer for a radix-2 SDF FFT    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module fft_twiddle_seq
   import fft_pkg::*;
#(
   parameter int N     = 128,
   parameter int STAGE = 0,
   parameter int W     = 24,
   parameter int FRAC  = 8,
   parameter int LAT   = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                in_valid,
   output logic signed [W-1:0] w_r,
   output logic signed [W-1:0] w_i,
   output logic [1:0]          state,
   output logic                out_valid,
   output logic                sof
);

   localparam int LOGN = clog2(N);
   localparam int D    = N >> (STAGE + 1);
   localparam int PW   = clog2(2 * D);
   localparam int KW   = LOGN - 1;
   localparam int LW   = (LAT > 0) ? clog2(LAT + 1) : 1;
   localparam int DW   = clog2(LAT + D + 1);

   localparam logic [PW-1:0]   C_D        = PW'(D);
   localparam logic [PW-1:0]   C_PMAX     = PW'(2 * D - 1);
   localparam logic [LOGN-1:0] C_SMAX     = LOGN'(N - 1);
   localparam logic [DW-1:0]   C_DRN      = DW'(LAT + D);
   localparam logic [DW-1:0]   C_DRN_LAST = DW'(LAT + D - 1);

   if (N < 4 || (N & (N - 1)) != 0) begin : g_chk_n
      $error("fft_twiddle_seq: N must be a power of two >= 4");
   end
   if (STAGE < 0 || STAGE >= LOGN) begin : g_chk_stage
      $error("fft_twiddle_seq: STAGE out of range");
   end
   if (FRAC > W - 2) begin : g_chk_frac
      $error("fft_twiddle_seq: FRAC must not exceed W-2");
   end

   logic [LW-1:0]   r_lat, w_lat_nx;
   logic [PW-1:0]   r_p, w_p_nx, w_pd;
   logic [LOGN-1:0] r_s, w_s_nx;
   logic [DW-1:0]   r_drn, w_drn_nx;
   logic            r_run, w_run_nx;
   logic            w_fill, w_load, w_adv, w_bypass;
   logic [KW-1:0]   w_k;
   stage_mode_e     r_mode, w_mode;
   logic            r_ov, r_sof;

   if (LAT > 0) begin : g_fill_cnt
      assign w_fill = (r_lat < LW'(LAT));
   end else begin : g_fill_none
      assign w_fill = 1'b0;
   end

   assign w_load   = (r_p < C_D);
   assign w_adv    = in_valid | (r_run & (r_drn < C_DRN));
   assign w_bypass = w_fill | w_load;
   assign w_pd     = r_p - C_D;
   assign w_k      = KW'(32'(w_pd) << STAGE);
   assign w_mode   = w_fill ? ST_FILL : (w_load ? ST_LOAD : ST_BFLY);

   // The final drain cycle still advances, then everything returns to idle.
   always_comb begin
      w_lat_nx = r_lat;
      w_p_nx   = r_p;
      w_s_nx   = r_s;
      w_drn_nx = r_drn;
      w_run_nx = r_run;
      if (w_adv) begin
         if (w_fill) begin
            w_lat_nx = r_lat + 1'b1;
         end else begin
            w_p_nx = (r_p == C_PMAX) ? '0 : r_p + 1'b1;
            w_s_nx = (r_s == C_SMAX) ? '0 : r_s + 1'b1;
         end
         if (in_valid) begin
            w_run_nx = 1'b1;
            w_drn_nx = '0;
         end else if (r_drn == C_DRN_LAST) begin
            w_lat_nx = '0;
            w_p_nx   = '0;
            w_s_nx   = '0;
            w_drn_nx = '0;
            w_run_nx = 1'b0;
         end else begin
            w_drn_nx = r_drn + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lat  <= '0;
         r_p    <= '0;
         r_s    <= '0;
         r_drn  <= '0;
         r_run  <= 1'b0;
         r_mode <= ST_FILL;
         r_ov   <= 1'b0;
         r_sof  <= 1'b0;
      end else if (clr) begin
         r_lat  <= '0;
         r_p    <= '0;
         r_s    <= '0;
         r_drn  <= '0;
         r_run  <= 1'b0;
         r_mode <= ST_FILL;
         r_ov   <= 1'b0;
         r_sof  <= 1'b0;
      end else begin
         r_lat  <= w_lat_nx;
         r_p    <= w_p_nx;
         r_s    <= w_s_nx;
         r_drn  <= w_drn_nx;
         r_run  <= w_run_nx;
         r_mode <= w_adv ? w_mode : ST_FILL;
         r_ov   <= w_adv;
         r_sof  <= w_adv & ~w_fill & (r_s == '0);
      end
   end

   fft_twiddle_rom #(
      .N   (N),
      .W   (W),
      .FRAC(FRAC),
      .KW  (KW)
   ) u_rom (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .i_en    (w_adv),
      .i_bypass(w_bypass),
      .i_k     (w_k),
      .o_w_r   (w_r),
      .o_w_i   (w_i)
   );

   assign state     = r_mode;
   assign out_valid = r_ov;
   assign sof       = r_sof;

endmodule
`default_nettype wire

// File: tb/tb_fft_twiddle_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_fft_twiddle_seq : directed bench for the SDF stage twiddle sequencer     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_fft_twiddle_seq;

   localparam int  NSW = 17;
   localparam real PI  = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;
   logic va = 1'b0, vb = 1'b0, vc = 1'b0, vs = 1'b0;

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic signed [23:0] a_wr, a_wi, b_wr, b_wi, c_wr, c_wi;
   logic [1:0]         a_st, b_st, c_st;
   logic               a_ov, a_sof, b_ov, b_sof, c_ov, c_sof;

   fft_twiddle_seq #(.N(8), .STAGE(1), .W(24), .FRAC(8), .LAT(2)) u_a (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(va), .w_r(a_wr), .w_i(a_wi),
      .state(a_st), .out_valid(a_ov), .sof(a_sof));

   fft_twiddle_seq #(.N(128), .STAGE(0), .W(24), .FRAC(8), .LAT(0)) u_b (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(vb), .w_r(b_wr), .w_i(b_wi),
      .state(b_st), .out_valid(b_ov), .sof(b_sof));

   fft_twiddle_seq #(.N(16), .STAGE(0), .W(24), .FRAC(8), .LAT(3)) u_c (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(vc), .w_r(c_wr), .w_i(c_wi),
      .state(c_st), .out_valid(c_ov), .sof(c_sof));

   function automatic int sw_n(input int j);
      return (j < 2) ? 4 : ((j < 7) ? 32 : 1024);
   endfunction

   function automatic int sw_st(input int j);
      return (j < 2) ? j : ((j < 7) ? j - 2 : j - 7);
   endfunction

   wire signed [23:0] s_wr [0:NSW-1];
   wire signed [23:0] s_wi [0:NSW-1];
   wire [1:0]         s_st [0:NSW-1];
   wire               s_ov [0:NSW-1];
   wire               s_sof[0:NSW-1];

   for (genvar j = 0; j < NSW; j++) begin : g_sweep
      fft_twiddle_seq #(.N(sw_n(j)), .STAGE(sw_st(j)), .W(24), .FRAC(8), .LAT(0)) u_s (
         .clk(clk), .rst(rst), .clr(clr), .in_valid(vs), .w_r(s_wr[j]), .w_i(s_wi[j]),
         .state(s_st[j]), .out_valid(s_ov[j]), .sof(s_sof[j]));
   end

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   int ea_st [10] = '{0, 0, 1, 1, 2, 2, 1, 1, 2, 2};
   int ea_wr [10] = '{256, 256, 256, 256, 256, 0, 256, 256, 256, 0};
   int ea_wi [10] = '{0, 0, 0, 0, 0, -256, 0, 0, 0, -256};
   int sbad  [NSW];
   int cnt;

   initial begin
      tick();
      tick();
      chk("rst_wr", a_wr, 256);
      chk("rst_wi", a_wi, 0);
      chk("rst_state", a_st, 0);
      chk("rst_ov", a_ov, 0);
      chk("rst_sof", a_sof, 0);
      rst = 1'b0;

      // N=8, STAGE=1, LAT=2 continuous burst
      va = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("a_state[%0d]", i), a_st, ea_st[i]);
         chk($sformatf("a_wr[%0d]", i), a_wr, ea_wr[i]);
         chk($sformatf("a_wi[%0d]", i), a_wi, ea_wi[i]);
         chk($sformatf("a_sof[%0d]", i), a_sof, (i == 2) ? 1 : 0);
      end
      chk("a_wi_raw", 64'(a_wi[23:0]), 64'h00FF_FF00);
      va = 1'b0;
      do_reset();

      // N=128, STAGE=0, LAT=0 continuous
      vb = 1'b1;
      cnt = 0;
      for (int t = 0; t < 256; t++) begin
         tick();
         cnt += int'(b_sof);
         if (t == 0)   chk("b_state0", b_st, 1);
         if (t == 63)  chk("b_state63", b_st, 1);
         if (t == 64) begin
            chk("b_state64", b_st, 2);
            chk("b_k0_wr", b_wr, 256);
            chk("b_k0_wi", b_wi, 0);
         end
         if (t == 80) begin
            chk("b_k16_wr", b_wr, 181);
            chk("b_k16_wi", b_wi, -181);
         end
         if (t == 96) begin
            chk("b_k32_wr", b_wr, 0);
            chk("b_k32_wi", b_wi, -256);
         end
         if (t == 128) chk("b_sof128", b_sof, 1);
      end
      chk("b_sof_count", cnt, 2);
      vb = 1'b0;
      do_reset();

      // N=16, STAGE=0, LAT=3: burst then full drain
      vc = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      vc = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         cnt += int'(c_ov);
      end
      chk("c_drain_len", cnt, 11);
      chk("c_idle_ov", c_ov, 0);

      // next burst restarts with FILL x3, then an interrupted drain
      vc = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (i < 3) begin
            chk($sformatf("d_fill_state[%0d]", i), c_st, 0);
            chk($sformatf("d_fill_ov[%0d]", i), c_ov, 1);
         end
         if (i == 3) begin
            chk("d_load_state", c_st, 1);
            chk("d_load_sof", c_sof, 1);
         end
      end
      vc = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("d_drain_ov[%0d]", i), c_ov, 1);
      end
      vc = 1'b1;
      tick();
      chk("d_resume_state", c_st, 2);
      chk("d_resume_wr", c_wr, -181);
      chk("d_resume_wi", c_wi, -181);
      tick();
      chk("d_k7_wr", c_wr, -237);
      chk("d_k7_wi", c_wi, -98);
      vc = 1'b0;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         cnt += int'(c_ov);
      end
      chk("d_redrain_len", cnt, 11);
      chk("d_hold_wr", c_wr, 181);
      chk("d_hold_wi", c_wi, -181);
      chk("d_hold_state", c_st, 0);
      chk("d_hold_ov", c_ov, 0);
      chk("d_hold_sof", c_sof, 0);

      // asynchronous rst in BFLY
      vc = 1'b1;
      for (int i = 0; i < 13; i++) tick();
      chk("e_pre_state", c_st, 2);
      chk("e_pre_wr", c_wr, 237);
      chk("e_pre_wi", c_wi, -98);
      #3 rst = 1'b1;
      #1;
      chk("e_async_wr", c_wr, 256);
      chk("e_async_wi", c_wi, 0);
      chk("e_async_state", c_st, 0);
      chk("e_async_ov", c_ov, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 0) chk("e_fill0_state", c_st, 0);
         if (i == 2) chk("e_fill2_ov", c_ov, 1);
         if (i == 3) chk("e_load_state", c_st, 1);
      end

      // clr together with in_valid
      for (int i = 0; i < 9; i++) tick();
      chk("f_pre_wr", c_wr, 237);
      clr = 1'b1;
      tick();
      chk("f_clr_wr", c_wr, 256);
      chk("f_clr_wi", c_wi, 0);
      chk("f_clr_state", c_st, 0);
      chk("f_clr_ov", c_ov, 0);
      chk("f_clr_sof", c_sof, 0);
      clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 2) chk("f_fill2_state", c_st, 0);
         if (i == 3) begin
            chk("f_load_state", c_st, 1);
            chk("f_load_sof", c_sof, 1);
         end
      end
      vc = 1'b0;
      do_reset();

      // sweep N in {4,32,1024}, every stage, against a double reference
      for (int j = 0; j < NSW; j++) sbad[j] = 0;
      vs = 1'b1;
      for (int t = 0; t < 1024; t++) begin
         tick();
         for (int j = 0; j < NSW; j++) begin
            int  n, st, d, p, k, est;
            real rr, ri;
            n  = sw_n(j);
            st = sw_st(j);
            d  = n >> (st + 1);
            p  = t % (2 * d);
            if (p < d) begin
               est = 1;
               rr  = 256.0;
               ri  = 0.0;
            end else begin
               est = 2;
               k   = (p - d) << st;
               rr  = $cos(2.0 * PI * real'(k) / real'(n)) * 256.0;
               ri  = -$sin(2.0 * PI * real'(k) / real'(n)) * 256.0;
            end
            if (s_st[j] !== 2'(est) || s_ov[j] !== 1'b1) sbad[j]++;
            if ((real'(s_wr[j]) - rr) > 1.0 || (rr - real'(s_wr[j])) > 1.0) sbad[j]++;
            if ((real'(s_wi[j]) - ri) > 1.0 || (ri - real'(s_wi[j])) > 1.0) sbad[j]++;
         end
      end
      vs = 1'b0;
      for (int j = 0; j < NSW; j++)
         chk($sformatf("sweep_N%0d_S%0d_bad", sw_n(j), sw_st(j)), sbad[j], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
